// File: rtl/array_reader.sv
// array_reader: an 8-entry memory with a write port, a handshaked random-read
// port and a self-sweeping scan checker. The scanner verifies mem[a] == a for
// every entry that has been written since reset. It latches the first mismatch
// address and exports the sticky result as safety1.
module array_reader #(
  parameter int AW = 3,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_hit,
  input  logic          scan_en,
  output logic          scan_busy,
  output logic          scan_done,
  output logic          err,
  output logic [AW-1:0] err_addr,
  output logic          safety1
);

  localparam int DEPTH = 1 << AW;

  // The scanner compares data against the zero-extended address, so the data
  // word must be at least as wide as the address.
  if (DW < AW) begin : g_bad_width
    $error("array_reader: DW (%0d) must be >= AW (%0d)", DW, AW);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        scan_addr_q, scan_addr_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DW-1:0]        chk_data_q, chk_data_d;
  logic                 chk_valid_q, chk_valid_d;
  logic                 err_q, err_d;
  logic [AW-1:0]        err_addr_q, err_addr_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;
  logic                 rd_hit_q, rd_hit_d;
  logic                 mismatch;
  logic [DW-1:0]        mem_q [DEPTH];

  // A CHECK-state entry that was written but does not hold its own address.
  assign mismatch = (state_q == S_CHECK) && chk_valid_q &&
                    (chk_data_q != DW'(scan_addr_q));

  // Next-state logic: scanner FSM, valid bitmap and random-read response.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so that no path leaves a value unassigned and infers a latch.
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    valid_d     = valid_q;
    chk_data_d  = chk_data_q;
    chk_valid_d = chk_valid_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    rd_data_d   = rd_data_q;
    rd_hit_d    = rd_hit_q;

    // The scanner owns the read port. A simultaneous scan_en wins over rd_req.
    rd_ack     = rd_req && (state_q == S_IDLE) && !scan_en;
    rd_valid_d = rd_ack;
    if (rd_ack) begin
      // The array is read before this edge's write lands, so a same-address
      // write is only seen by a later read.
      rd_data_d = mem_q[rd_addr];
      rd_hit_d  = valid_q[rd_addr];
    end

    unique case (state_q)
      S_IDLE: begin
        if (scan_en) begin
          state_d     = S_READ;
          scan_addr_d = '0;
        end
      end
      S_READ: begin
        chk_data_d  = mem_q[scan_addr_q];
        chk_valid_d = valid_q[scan_addr_q];
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = 1'b1;
          if (!err_q) err_addr_d = scan_addr_q;
        end
        if (scan_addr_q == AW'(DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
          scan_addr_d = scan_addr_q + 1'b1;
          state_d     = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Writes are accepted in every state and mark the entry as written.
    if (wr_en) valid_d[wr_addr] = 1'b1;
  end

  // Control and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      scan_addr_q <= '0;
      valid_q     <= '0;
      chk_data_q  <= '0;
      chk_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      valid_q     <= valid_d;
      chk_data_q  <= chk_data_d;
      chk_valid_q <= chk_valid_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; stale contents are masked by valid_q, which is reset.
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_hit    = rd_hit_q;
  assign scan_busy = (state_q != S_IDLE);
  assign scan_done = (state_q == S_DONE);
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign safety1   = !err_q;

  // safety1 may only drop right after a CHECK that saw a written entry mismatch.
  a_safety1_stable : assert property (
    @(posedge clk) disable iff (rst)
      (!safety1 && $past(safety1)) |-> $past(mismatch)
  );

endmodule

// File: tb/tb_array_reader.sv
// tb_array_reader: randomized and directed stimulus checked against a
// behavioural model. The model tracks memory contents, written flags and scan
// progress as a cycle count within a 17-cycle sweep. Read responses go through
// a scoreboard queue, and a negedge monitor compares every DUT output.
module tb_array_reader;

  localparam int AW    = 3;
  localparam int DW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int SCAN_LEN = 2 * DEPTH + 1;  // cycles a sweep keeps scan_busy high

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_hit;
  logic          scan_en;
  logic          scan_busy;
  logic          scan_done;
  logic          err;
  logic [AW-1:0] err_addr;
  logic          safety1;

  array_reader #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_hit    (rd_hit),
    .scan_en   (scan_en),
    .scan_busy (scan_busy),
    .scan_done (scan_done),
    .err       (err),
    .err_addr  (err_addr),
    .safety1   (safety1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic          hit;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] m_mem   [DEPTH];
  logic          m_valid [DEPTH];
  logic          m_err;
  logic [AW-1:0] m_err_addr;
  int            m_phase;      // 0 = idle, 1..SCAN_LEN = cycle within a sweep
  logic [DW-1:0] m_samp_data;
  logic          m_samp_valid;
  bit            started = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_err      = 1'b0;
    m_err_addr = '0;
    m_phase    = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_err      = 1'b0;
      m_err_addr = '0;
      m_phase    = 0;
      exp_q.delete();
    end else begin
      int k;
      if (rd_req && m_phase == 0 && !scan_en) begin
        rsp_t r;
        r.data = m_mem[rd_addr];
        r.hit  = m_valid[rd_addr];
        exp_q.push_back(r);
      end
      // Sweep cycle 2k+1 samples entry k, cycle 2k+2 judges it.
      if (m_phase != 0 && m_phase != SCAN_LEN) begin
        k = (m_phase - 1) / 2;
        if (m_phase % 2 == 1) begin
          m_samp_data  = m_mem[k];
          m_samp_valid = m_valid[k];
        end else if (m_samp_valid && m_samp_data != DW'(k)) begin
          if (!m_err) m_err_addr = AW'(k);
          m_err = 1'b1;
        end
      end
      if (m_phase == 0) begin
        if (scan_en) m_phase = 1;
      end else if (m_phase == SCAN_LEN) begin
        m_phase = 0;
      end else begin
        m_phase++;
      end
      if (wr_en) begin
        m_mem[wr_addr]   = wr_data;
        m_valid[wr_addr] = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (started) begin
      check("rd_ack", rd_ack, rd_req && m_phase == 0 && !scan_en);
      check("scan_busy", scan_busy, m_phase != 0);
      check("scan_done", scan_done, m_phase == SCAN_LEN);
      check("err", err, m_err);
      check("err_addr", err_addr, m_err_addr);
      check("safety1", safety1, !m_err);
      check("rd_valid", rd_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        rsp_t r;
        r = exp_q.pop_front();
        if (rd_valid) begin
          check("rd_hit", rd_hit, r.hit);
          if (r.hit) check("rd_data", rd_data, r.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
    cycle();
    wr_en = 1'b0;
  endtask

  // Hold a request until the DUT accepts it, with a bounded wait.
  task automatic do_read(input int a);
    logic got;
    got = 1'b0;
    rd_req = 1'b1; rd_addr = AW'(a);
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      got = rd_ack;
      cycle();
    end
    check("rd_ack_timeout", got, 1'b1);
    rd_req = 1'b0;
    cycle();
  endtask

  task automatic do_scan();
    scan_en = 1'b1;
    cycle();
    scan_en = 1'b0;
    repeat (SCAN_LEN) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; scan_en = 1'b0;
    cycle();
    started = 1;
    do_reset();

    // Empty memory: clean sweep, unwritten read misses.
    do_scan();
    check("empty_scan_err", err, 1'b0);
    do_read(5);

    // Writer pattern then a clean sweep.
    for (int i = 0; i < DEPTH; i++) do_write(i, i);
    do_scan();
    check("pattern_scan_safety1", safety1, 1'b1);
    do_read(3);

    // Two corrupt entries: only the first is recorded; err survives a rescan.
    do_write(2, 5);
    do_write(6, 1);
    do_scan();
    check("corrupt_err", err, 1'b1);
    check("corrupt_err_addr", err_addr, 3'd2);
    do_scan();
    check("rescan_err_addr", err_addr, 3'd2);

    // Same-cycle write and read of addr 4: old data first, new data next.
    do_write(4, 4);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 3'd7;
    rd_req = 1'b1; rd_addr = 3'd4;
    cycle();
    wr_en = 1'b0; rd_req = 1'b0;
    cycle();
    do_read(4);

    // Read held across a sweep, then scan_en colliding with rd_req.
    scan_en = 1'b1;
    cycle();
    scan_en = 1'b0;
    do_read(1);
    scan_en = 1'b1; rd_req = 1'b1; rd_addr = 3'd0;
    cycle();
    scan_en = 1'b0;
    do_read(0);
    repeat (SCAN_LEN) cycle();

    // Reset during the CHECK of addr 3 with a pending mismatch.
    do_reset();
    do_write(3, 6);
    scan_en = 1'b1;
    cycle();
    scan_en = 1'b0;
    repeat (7) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midscan_busy", scan_busy, 1'b0);
    check("midscan_err", err, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_read(i);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 399) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(0, 7)) : DW'(wr_addr);
      scan_en = ($urandom_range(0, 24) == 0);
      if (!(rd_req && !rd_ack)) begin
        rd_req  = $urandom_range(0, 1);
        rd_addr = AW'($urandom_range(0, DEPTH - 1));
      end
      cycle();
    end
    rst = 1'b0; wr_en = 1'b0; rd_req = 1'b0; scan_en = 1'b0;
    repeat (SCAN_LEN + 2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/array_reader.md
Name: array_reader

Overview:
- Read-side companion to the counter-driven array writer: an 8-entry memory with a write port, a handshaked random-read port and a self-sweeping scan checker.
- The scanner walks every written entry and checks the writer's invariant, mem[a] == a.
- Its sticky result is exported as safety1, so word-level model checkers and simulation benches consume the same property.
- Sits directly downstream of the writer; the writer drives wr_*, and a host or bench drives the read and scan controls.

Parameters:
- AW, 3, address width; DEPTH = 2**AW entries.
- DW, 3, data width; must satisfy DW >= AW (elaboration error otherwise).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- rd_req  in  1  random-read request; hold until rd_ack
- rd_addr  in  AW  read address; hold with rd_req
- rd_ack  out  1  request accepted this cycle (combinational)
- rd_valid  out  1  one-cycle pulse; rd_data/rd_hit valid
- rd_data  out  DW  read data
- rd_hit  out  1  entry read had been written since reset
- scan_en  in  1  start-scan pulse (sampled in IDLE only)
- scan_busy  out  1  scanner owns the read port
- scan_done  out  1  one-cycle pulse at end of sweep
- err  out  1  sticky mismatch flag
- err_addr  out  AW  address of first mismatch
- safety1  out  1  equals !err

Behaviour:
- Reset: FSM=IDLE, valid bitmap=0, rd_valid=0, rd_data=0, rd_hit=0, scan_busy=0, scan_done=0, err=0, err_addr=0, safety1=1. Memory contents are not reset; they are masked by the valid bits.
- Write: at the edge with wr_en=1, mem[wr_addr] <= wr_data and valid[wr_addr] <= 1. Writes are accepted in every state, including during a scan.
- Read/write same address in the same cycle: the read returns the old data and the old valid bit (read-before-write).
- Random read:
  - rd_ack = rd_req && state==IDLE && !scan_en.
  - If scan_en and rd_req are high together, the scan wins.
  - On ack at edge t, rd_valid=1 in cycle t+1, with rd_data=mem[rd_addr] and rd_hit=valid[rd_addr].
  - An unacked request produces no response.
  - One read per cycle; back-to-back acks are allowed.
- Scanner FSM states: IDLE, READ, CHECK, DONE.
  - IDLE -> READ when scan_en=1; scan_addr <= 0.
  - READ: register mem[scan_addr] and valid[scan_addr] -> CHECK.
  - CHECK: if the sampled valid bit is set and the data != zero-extend(scan_addr), raise err. On the first error only, err_addr <= scan_addr.
  - CHECK -> DONE if scan_addr == DEPTH-1; otherwise scan_addr+1 -> READ. No wrap.
  - DONE: scan_done=1 for one cycle -> IDLE.
- Scan timing:
  - scan_busy=1 in READ, CHECK and DONE.
  - With DEPTH=8, scan_en at edge t gives scan_done high in cycle t+17 and scan_busy high in cycles t+1..t+17.
  - scan_en while busy is ignored.
- Writes during a scan are not rechecked for addresses already passed. A write to the address being read in READ is seen in the next scan.
- err is sticky until rst and is never cleared by a new scan. A later mismatch does not move err_addr.
- Reset mid-scan: at the next edge the FSM returns to IDLE, all flags clear and valid bits clear; no scan_done is generated.
- Property (embedded assertion): safety1 is stable 1 unless some CHECK state saw a valid mismatch.

Test Plan:
- Reset, then scan with no writes -> scan_done at t+17, err=0, safety1=1; a read of addr 5 gives rd_hit=0.
- Writer pattern mem[i]=i for i=0..7, then scan -> err=0; a read of addr 3 gives rd_data=3, rd_hit=1, rd_valid one cycle after rd_ack.
- Write mem[2]=5 and mem[6]=1, then scan -> err=1 after the CHECK of addr 2, err_addr=2 (unchanged by addr 6), safety1=0; err persists through a second scan.
- rd_req held while a scan runs -> rd_ack=0 for cycles t+1..t+17, acked in the first IDLE cycle; scan_en and rd_req asserted together -> scan starts, no ack.
- Same-cycle wr_en/rd_ack to addr 4 (old 4, new 7) -> rd_data=4; next read -> 7.
- Assert rst during CHECK at addr 3 with a pending mismatch -> next cycle IDLE, err=0, scan_busy=0, no scan_done pulse, all rd_hit=0.
